// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle for muldiv_unit.
// master: the issuing pipeline / writeback arbiter side; slave: the unit.
interface muldiv_unit_if #(
   parameter int REG_WIDTH = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           funct3;
   logic [REG_WIDTH-1:0] op_a;
   logic [REG_WIDTH-1:0] op_b;
   logic [4:0]           rd_in;
   logic                 kill;
   logic                 wb_grant;
   logic                 busy;
   logic [4:0]           rd;
   logic [REG_WIDTH-1:0] rd_din;
   logic                 reg_write;

   modport master (
      output in_valid, funct3, op_a, op_b, rd_in, kill, wb_grant,
      input  in_ready, busy, rd, rd_din, reg_write
   );

   modport slave (
      input  in_valid, funct3, op_a, op_b, rd_in, kill, wb_grant,
      output in_ready, busy, rd, rd_din, reg_write
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Multiply: one shift-add step per cycle; divide: one restoring
// shift-subtract step per cycle. Operands are converted to magnitudes on
// accept and the sign is restored in the last CALC cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip CALC and go straight to DONE.
// REG_WIDTH must be even and >= 8.
module muldiv_unit #(
   parameter int REG_WIDTH = 64
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int W  = REG_WIDTH;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      funct3_reg;
   logic [4:0]      rd_reg;
   logic [CW-1:0]   count_reg;
   // hi/lo: product high/low for multiply, remainder/quotient for divide.
   logic [W-1:0]    hi_reg, lo_reg;
   // multiplicand for multiply, divisor for divide
   logic [W-1:0]    opnd_reg;
   logic [W-1:0]    rd_din_reg;
   logic            neg_res_reg;   // negate product / quotient
   logic            neg_rem_reg;   // negate remainder (dividend was negative)

   logic            accept;
   logic            reg_write_c;
   logic            is_div_in, a_signed_in, b_signed_in;
   logic            neg_a_in, neg_b_in, b_zero_in;
   logic [W-1:0]    mag_a_in, mag_b_in;
   logic            early_in;
   logic [W-1:0]    early_res;
   logic [W:0]      mul_sum, div_trial;
   logic [W-1:0]    step_hi, step_lo;
   logic [W-1:0]    hi_carry;
   logic [W-1:0]    fixed_res;

   // Operand decode: signedness, sign flags and magnitudes of the request.
   always_comb begin
      is_div_in   = bus.funct3[2];
      a_signed_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      b_signed_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
      neg_a_in    = a_signed_in && bus.op_a[W-1];
      neg_b_in    = b_signed_in && bus.op_b[W-1];
      mag_a_in    = neg_a_in ? (~bus.op_a + 1'b1) : bus.op_a;
      mag_b_in    = neg_b_in ? (~bus.op_b + 1'b1) : bus.op_b;
      b_zero_in   = (bus.op_b == '0);
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic ovf_in;

   // Special cases whose result is known at accept time.
   always_comb begin
      ovf_in    = !bus.funct3[0] && (bus.op_a == {1'b1, {(W-1){1'b0}}}) &&
                  (bus.op_b == '1);
      early_in  = 1'b0;
      early_res = '0;
      if (is_div_in) begin
         if (b_zero_in) begin
            early_in  = 1'b1;
            early_res = bus.funct3[1] ? bus.op_a : '1;
         end else if (ovf_in) begin
            early_in  = 1'b1;
            early_res = bus.funct3[1] ? '0 : bus.op_a;
         end
      end else if ((bus.op_a == '0) || b_zero_in) begin
         early_in = 1'b1;
      end
   end
`else
   assign early_in  = 1'b0;
   assign early_res = '0;
`endif

   // One iteration step for multiply (shift-add) and divide (restoring).
   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      div_trial = {hi_reg, lo_reg[W-1]} - {1'b0, opnd_reg};
      step_hi   = '0;
      step_lo   = '0;
      if (funct3_reg[2]) begin
         // A zero divisor never underflows, so the quotient fills with ones
         // and the remainder collects the whole dividend.
         if (!div_trial[W]) begin
            step_hi = div_trial[W-1:0];
            step_lo = {lo_reg[W-2:0], 1'b1};
         end else begin
            step_hi = {hi_reg[W-2:0], lo_reg[W-1]};
            step_lo = {lo_reg[W-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[W:1];
         step_lo = {mul_sum[0], lo_reg[W-1:1]};
      end
   end

   // Sign fix and result selection from the finished magnitudes.
   always_comb begin
      // High half of -{hi,lo}: the +1 only carries into hi when lo is zero.
      hi_carry  = ~hi_reg + W'(lo_reg == '0);
      fixed_res = '0;
      case (funct3_reg)
         3'b000:                 fixed_res = lo_reg;
         3'b001, 3'b010, 3'b011: fixed_res = neg_res_reg ? hi_carry : hi_reg;
         3'b100, 3'b101:         fixed_res = neg_res_reg ? (~lo_reg + 1'b1) : lo_reg;
         default:                fixed_res = neg_rem_reg ? (~hi_reg + 1'b1) : hi_reg;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state and write strobe; kill beats both in_valid and wb_grant.
   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      reg_write_c = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid && !bus.kill) begin
               accept     = 1'b1;
               state_next = early_in ? DONE : CALC;
            end
         end
         CALC: begin
            if (bus.kill)                      state_next = IDLE;
            else if (count_reg == CW'(W))      state_next = DONE;
         end
         DONE: begin
            // x0 results are dropped but DONE still waits for the grant.
            reg_write_c = bus.wb_grant && !bus.kill && (rd_reg != 5'd0);
            if (bus.kill || bus.wb_grant)      state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, iterate in CALC, sign fix at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_reg  <= '0;
         rd_reg      <= '0;
         count_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         opnd_reg    <= '0;
         rd_din_reg  <= '0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  funct3_reg  <= bus.funct3;
                  rd_reg      <= bus.rd_in;
                  count_reg   <= '0;
                  hi_reg      <= '0;
                  // A zero divisor keeps the quotient all ones for DIV too.
                  neg_res_reg <= (neg_a_in ^ neg_b_in) && !(is_div_in && b_zero_in);
                  neg_rem_reg <= neg_a_in;
                  if (is_div_in) begin
                     lo_reg   <= mag_a_in;
                     opnd_reg <= mag_b_in;
                  end else begin
                     lo_reg   <= mag_b_in;
                     opnd_reg <= mag_a_in;
                  end
                  if (early_in) rd_din_reg <= early_res;
               end
            end
            CALC: begin
               if (count_reg == CW'(W)) begin
                  rd_din_reg <= fixed_res;
               end else begin
                  hi_reg    <= step_hi;
                  lo_reg    <= step_lo;
                  count_reg <= count_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.rd        = rd_reg;
   assign bus.rd_din    = rd_din_reg;
   assign bus.reg_write = reg_write_c;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (REG_WIDTH = 64).
module tb_muldiv_unit;
   localparam int W = 64;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 0;
`else
   localparam int SPECIAL_LAT = 65;
`endif
   localparam int FULL_LAT = 65;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit_if #(.REG_WIDTH(W)) bus ();

   muldiv_unit #(.REG_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op with wb_grant=1, wait for the write, check latency and data.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r,
                         input logic [63:0] exp, input int lat);
      int cyc;
      bus.funct3   = f;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.rd_in    = r;
      bus.in_valid = 1'b1;
      bus.wb_grant = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      cyc = 0;
      while (bus.reg_write !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_rd"}, 64'(bus.rd), 64'(r));
      chk({tag, "_rd_din"}, bus.rd_din, exp);
      @(posedge clk); #1;
      chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
      $display("op %s f=%0d a=%h b=%h rd=%0d -> rd_din=%h lat=%0d", tag, f, a, b, r, bus.rd_din, cyc);
   endtask

   initial begin
      int cyc;
      int writes;
      bus.in_valid = 1'b0;
      bus.funct3   = 3'b000;
      bus.op_a     = '0;
      bus.op_b     = '0;
      bus.rd_in    = '0;
      bus.kill     = 1'b0;
      bus.wb_grant = 1'b1;

      // Reset state
      #12;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
      chk("rst_rd", 64'(bus.rd), 64'd0);
      chk("rst_rd_din", bus.rd_din, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Main function
      run_op("mul",    3'b000, 64'd10, 64'd18, 5'd3, 64'd180, FULL_LAT);
      run_op("mulh",   3'b001, '1, 64'd2, 5'd5, '1, FULL_LAT);
      run_op("mulhu",  3'b011, '1, 64'd2, 5'd5, 64'd1, FULL_LAT);
      run_op("mulhsu", 3'b010, '1, 64'd2, 5'd6, '1, FULL_LAT);
      run_op("mul_big", 3'b000, 64'h0000_0001_0000_0003, 64'h0000_0002_0000_0005, 5'd8,
             64'h0000_000B_0000_000F, FULL_LAT);
      run_op("div",    3'b100, -64'sd7, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, FULL_LAT);
      run_op("rem",    3'b110, -64'sd7, 64'd2, 5'd9, '1, FULL_LAT);
      run_op("divu",   3'b101, 64'd100, 64'd7, 5'd10, 64'd14, FULL_LAT);
      run_op("remu",   3'b111, 64'd100, 64'd7, 5'd10, 64'd2, FULL_LAT);
      // Boundary cases
      run_op("divu_z", 3'b101, 64'd7, 64'd0, 5'd11, '1, SPECIAL_LAT);
      run_op("remu_z", 3'b111, 64'd7, 64'd0, 5'd11, 64'd7, SPECIAL_LAT);
      run_op("div_z",  3'b100, -64'sd5, 64'd0, 5'd12, '1, SPECIAL_LAT);
      run_op("rem_z",  3'b110, -64'sd5, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFB, SPECIAL_LAT);
      run_op("div_ovf", 3'b100, 64'h8000_0000_0000_0000, '1, 5'd13, 64'h8000_0000_0000_0000, SPECIAL_LAT);
      run_op("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, '1, 5'd13, 64'd0, SPECIAL_LAT);

      // MUL to x0: no write strobe at any point, unit still drains
      bus.funct3 = 3'b000; bus.op_a = 64'd3; bus.op_b = 64'd4; bus.rd_in = 5'd0;
      bus.in_valid = 1'b1; bus.wb_grant = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      writes = 0;
      for (int i = 0; i < 70; i++) begin
         if (bus.reg_write === 1'b1) writes++;
         @(posedge clk); #1;
      end
      chk("x0_writes", 64'(writes), 64'd0);
      chk("x0_idle", 64'(bus.in_ready), 64'd1);
      $display("op x0 mul writes=%0d in_ready=%0d", writes, bus.in_ready);

      // kill in IDLE blocks acceptance
      bus.funct3 = 3'b101; bus.op_a = 64'd9; bus.op_b = 64'd3; bus.rd_in = 5'd4;
      bus.in_valid = 1'b1; bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.kill = 1'b0;
      chk("kill_idle_busy", 64'(bus.busy), 64'd0);
      $display("op kill-in-idle busy=%0d", bus.busy);

      // kill at cycle 20 of a DIV
      bus.funct3 = 3'b100; bus.op_a = -64'sd7; bus.op_b = 64'd2; bus.rd_in = 5'd4;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      writes = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.reg_write === 1'b1) writes++;
         @(posedge clk); #1;
      end
      bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
      chk("kill_busy", 64'(bus.busy), 64'd0);
      chk("kill_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 70; i++) begin
         if (bus.reg_write === 1'b1) writes++;
         @(posedge clk); #1;
      end
      chk("kill_writes", 64'(writes), 64'd0);
      $display("op kill div writes=%0d", writes);
      run_op("after_kill", 3'b101, 64'd100, 64'd7, 5'd14, 64'd14, FULL_LAT);

      // Asynchronous reset at cycle 30 of a MUL
      bus.funct3 = 3'b000; bus.op_a = 64'd6; bus.op_b = 64'd7; bus.rd_in = 5'd15;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("arst_reg_write", 64'(bus.reg_write), 64'd0);
      chk("arst_rd_din", bus.rd_din, 64'd0);
      #2;
      rst_n = 1'b1;
      writes = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (bus.reg_write === 1'b1) writes++;
      end
      chk("arst_writes", 64'(writes), 64'd0);
      $display("op async reset mid-mul busy=%0d writes=%0d", bus.busy, writes);

      // Hold wb_grant low in DONE
      bus.funct3 = 3'b000; bus.op_a = 64'd3; bus.op_b = 64'd5; bus.rd_in = 5'd7;
      bus.wb_grant = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < FULL_LAT; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold_busy", 64'(bus.busy), 64'd1);
         chk("hold_rd", 64'(bus.rd), 64'd7);
         chk("hold_rd_din", bus.rd_din, 64'd15);
         chk("hold_reg_write", 64'(bus.reg_write), 64'd0);
         @(posedge clk); #1;
      end
      bus.wb_grant = 1'b1;
      #1;
      chk("hold_release_write", 64'(bus.reg_write), 64'd1);
      chk("hold_release_rd_din", bus.rd_din, 64'd15);
      @(posedge clk); #1;
      chk("hold_release_idle", 64'(bus.in_ready), 64'd1);
      $display("op wb_grant hold rd=%0d rd_din=%h in_ready=%0d", bus.rd, bus.rd_din, bus.in_ready);

      cyc = checks;
      $display("CHECKS %0d ERRORS %0d", cyc, errors);
      $finish;
   end
endmodule
